// File: rtl/pipelined_decoder.sv
// pipelined_decoder
//
// Decodes raw RV32 instruction words into their register/function fields, a
// sign-extended immediate and a format code. Results are registered into a
// two-entry FIFO: a head entry that drives the outputs and a skid entry that
// absorbs one extra word while the consumer stalls. in_ready is a register, so
// there is no combinational path from out_ready back to in_ready.
//
// Parameters
//   XLEN  immediate output width (32 or 64)
//   PC_W  width of the program counter carried alongside each instruction
//
// Ports
//   clk, reset         clock, asynchronous active-high reset
//   in_valid/in_ready  upstream handshake for instruction + pc
//   instruction, pc    raw instruction word and its address
//   flush              drop every held entry and the word offered this cycle
//   out_valid/out_ready downstream handshake for the head entry
//   opcode..funct7     decoded fields of the head entry
//   imm, fmt, illegal  immediate, format code (0=R 1=I 2=S 3=B 4=U 5=J 7=bad)
//                      and illegal flag of the head entry
//   pc_out             pc of the head entry

module pipelined_decoder #(
    parameter int XLEN = 32,
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instruction,
    input  logic [PC_W-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [2:0]      funct3,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic [2:0]      fmt,
    output logic            illegal,
    output logic [PC_W-1:0] pc_out
);

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_BAD = 3'd7;

    typedef struct packed {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } entry_t;

    entry_t     dec;
    entry_t     head;
    entry_t     skid;
    logic       head_valid;
    logic       skid_valid;
    logic       xfer_in;
    logic       xfer_out;
    logic [31:0] imm32;

    // Combinational decode of the word currently offered upstream. The
    // immediate is first built as 32 bits, then widened by replicating bit 31
    // so both XLEN settings share one path.
    always_comb begin
        dec         = '0;
        imm32       = '0;
        dec.opcode  = instruction[6:0];
        dec.rd      = instruction[11:7];
        dec.funct3  = instruction[14:12];
        dec.rs1     = instruction[19:15];
        dec.rs2     = instruction[24:20];
        dec.funct7  = instruction[31:25];
        dec.pc      = pc;

        case (instruction[6:0])
            7'b0110011:                                     dec.fmt = FMT_R;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: dec.fmt = FMT_I;
            7'b0100011:                                     dec.fmt = FMT_S;
            7'b1100011:                                     dec.fmt = FMT_B;
            7'b0110111, 7'b0010111:                         dec.fmt = FMT_U;
            7'b1101111:                                     dec.fmt = FMT_J;
            default:                                        dec.fmt = FMT_BAD;
        endcase

        // Every supported opcode already ends in 2'b11; the explicit test
        // keeps the flag correct should the opcode table ever grow.
        dec.illegal = (dec.fmt == FMT_BAD) || (instruction[1:0] != 2'b11);

        case (dec.fmt)
            FMT_I: imm32 = {{20{instruction[31]}}, instruction[31:20]};
            FMT_S: imm32 = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            FMT_B: imm32 = {{19{instruction[31]}}, instruction[31], instruction[7],
                            instruction[30:25], instruction[11:8], 1'b0};
            FMT_U: imm32 = {instruction[31:12], 12'b0};
            FMT_J: imm32 = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                            instruction[20], instruction[30:21], 1'b0};
            default: imm32 = '0;
        endcase

        dec.imm       = {XLEN{imm32[31]}};
        dec.imm[31:0] = imm32;
    end

    // The skid slot only takes data while it is empty, so in_ready is simply
    // its registered emptiness.
    always_comb begin
        xfer_in  = in_valid && !skid_valid;
        xfer_out = head_valid && out_ready;
    end

    // Two-entry FIFO. The skid can only be occupied while the head is, so the
    // three legal occupancies are: empty, head only, head + skid. flush wins
    // over every transfer, including the word offered in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
            head       <= '0;
            skid       <= '0;
        end else if (flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!head_valid) begin
            if (xfer_in) begin
                head       <= dec;
                head_valid <= 1'b1;
            end
        end else if (skid_valid) begin
            if (xfer_out) begin
                head       <= skid;
                skid_valid <= 1'b0;
            end
        end else begin
            if (xfer_in && xfer_out) begin
                head <= dec;
            end else if (xfer_in) begin
                skid       <= dec;
                skid_valid <= 1'b1;
            end else if (xfer_out) begin
                head_valid <= 1'b0;
            end
        end
    end

    // Outputs come straight from the head register, so they hold steady for
    // as long as the consumer stalls.
    always_comb begin
        in_ready  = !skid_valid;
        out_valid = head_valid;
        opcode    = head.opcode;
        rd        = head.rd;
        funct3    = head.funct3;
        rs1       = head.rs1;
        rs2       = head.rs2;
        funct7    = head.funct7;
        imm       = head.imm;
        fmt       = head.fmt;
        illegal   = head.illegal;
        pc_out    = head.pc;
    end

endmodule

// File: tb/tb_pipelined_decoder.sv
// tb_pipelined_decoder
//
// Directed testbench for pipelined_decoder. A reference model (queue of
// decoded entries, at most two deep) is updated on every rising edge and a
// compare process checks the DUT against it on every falling edge. Directed
// steps additionally check hand-computed literal values.

module tb_pipelined_decoder;

    localparam int XLEN = 32;
    localparam int PC_W = 32;

    logic            clk;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     instruction;
    logic [PC_W-1:0] pc;
    logic            flush;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      opcode;
    logic [4:0]      rd;
    logic [2:0]      funct3;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [6:0]      funct7;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic            illegal;
    logic [PC_W-1:0] pc_out;

    int checks = 0;
    int errors = 0;

    pipelined_decoder #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .instruction(instruction), .pc(pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rd(rd), .funct3(funct3), .rs1(rs1), .rs2(rs2),
        .funct7(funct7), .imm(imm), .fmt(fmt), .illegal(illegal),
        .pc_out(pc_out)
    );

    // Free-running 10-unit clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]      opcode;
        logic [4:0]      rd;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [6:0]      funct7;
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [PC_W-1:0] pc;
    } model_t;

    model_t q[$];

    // Reference decode written from the instruction-set rules: pick the format
    // from the opcode, then form the immediate as a signed integer.
    function automatic model_t model_decode(input logic [31:0] w, input logic [PC_W-1:0] p);
        model_t m;
        longint v;
        m.opcode = w[6:0];
        m.rd     = w[11:7];
        m.funct3 = w[14:12];
        m.rs1    = w[19:15];
        m.rs2    = w[24:20];
        m.funct7 = w[31:25];
        m.pc     = p;
        case (w[6:0])
            7'b0110011:                                     m.fmt = 3'd0;
            7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: m.fmt = 3'd1;
            7'b0100011:                                     m.fmt = 3'd2;
            7'b1100011:                                     m.fmt = 3'd3;
            7'b0110111, 7'b0010111:                         m.fmt = 3'd4;
            7'b1101111:                                     m.fmt = 3'd5;
            default:                                        m.fmt = 3'd7;
        endcase
        m.illegal = (m.fmt == 3'd7) || (w[1:0] != 2'b11);
        v = 0;
        case (m.fmt)
            3'd1: v = $signed(w[31:20]);
            3'd2: v = $signed({w[31:25], w[11:7]});
            3'd3: v = $signed({w[31], w[7], w[30:25], w[11:8], 1'b0});
            3'd4: v = $signed({w[31:12], 12'b0});
            3'd5: v = $signed({w[31], w[19:12], w[20], w[30:21], 1'b0});
            default: v = 0;
        endcase
        m.imm = v[XLEN-1:0];
        return m;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Model update on the same edges the DUT sees; flush discards everything.
    always @(posedge clk or posedge reset) begin
        bit acc;
        bit pop;
        if (reset) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            pop = out_ready && (q.size() > 0);
            if (flush) begin
                q.delete();
            end else begin
                if (pop) void'(q.pop_front());
                if (acc) q.push_back(model_decode(instruction, pc));
            end
        end
    end

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("out_valid", out_valid, q.size() > 0);
        checkOutput("in_ready", in_ready, q.size() < 2);
        if (q.size() > 0) begin
            checkOutput("opcode", opcode, q[0].opcode);
            checkOutput("rd", rd, q[0].rd);
            checkOutput("funct3", funct3, q[0].funct3);
            checkOutput("rs1", rs1, q[0].rs1);
            checkOutput("rs2", rs2, q[0].rs2);
            checkOutput("funct7", funct7, q[0].funct7);
            checkOutput("imm", imm, q[0].imm);
            checkOutput("fmt", fmt, q[0].fmt);
            checkOutput("illegal", illegal, q[0].illegal);
            checkOutput("pc_out", pc_out, q[0].pc);
        end
    end

    // Drive one cycle of inputs, let the edge take them, return 1 unit later.
    task automatic applyStimulus(input logic v, input logic [31:0] w,
                                 input logic [PC_W-1:0] p, input logic ordy,
                                 input logic fl);
        in_valid    = v;
        instruction = w;
        pc          = p;
        out_ready   = ordy;
        flush       = fl;
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] BEQ  = 32'hFE000EE3;
    localparam logic [31:0] ADD  = 32'h002081B3;
    localparam logic [31:0] SW   = 32'h00112623;
    localparam logic [31:0] LUI  = 32'h123450B7;

    logic [31:0] mix [12];

    initial begin
        mix = '{32'h002081B3, 32'hFFC12083, 32'h00112623, 32'h123450B7,
                32'h00000517, 32'hFF5FF0EF, 32'h000080E7, 32'h00000073,
                32'h00209463, 32'hFFFFFFFF, 32'h00000002, 32'h80000037};

        reset = 1'b1;
        in_valid = 1'b0; instruction = '0; pc = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset out_valid", out_valid, 1'b0);
        checkOutput("reset in_ready", in_ready, 1'b1);
        checkOutput("reset imm", imm, '0);
        checkOutput("reset fmt", fmt, 3'd0);
        @(negedge clk);
        reset = 1'b0;

        // addi x1,x0,5
        applyStimulus(1'b1, ADDI, 32'h100, 1'b1, 1'b0);
        checkOutput("addi out_valid", out_valid, 1'b1);
        checkOutput("addi opcode", opcode, 7'h13);
        checkOutput("addi rd", rd, 5'd1);
        checkOutput("addi rs1", rs1, 5'd0);
        checkOutput("addi fmt", fmt, 3'd1);
        checkOutput("addi imm", imm, 32'd5);

        // beq x0,x0,-4 replaces addi in the same cycle addi is consumed
        applyStimulus(1'b1, BEQ, 32'h104, 1'b1, 1'b0);
        checkOutput("beq fmt", fmt, 3'd3);
        checkOutput("beq imm", imm, 32'hFFFFFFFC);
        checkOutput("beq pc", pc_out, 32'h104);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("drain out_valid", out_valid, 1'b0);

        // Stalled consumer: three offers, only two fit
        applyStimulus(1'b1, ADD, 32'h200, 1'b0, 1'b0);
        checkOutput("stall1 in_ready", in_ready, 1'b1);
        checkOutput("stall1 pc", pc_out, 32'h200);
        applyStimulus(1'b1, SW, 32'h204, 1'b0, 1'b0);
        checkOutput("stall2 in_ready", in_ready, 1'b0);
        checkOutput("stall2 pc", pc_out, 32'h200);
        applyStimulus(1'b1, LUI, 32'h208, 1'b0, 1'b0);
        checkOutput("stall3 in_ready", in_ready, 1'b0);
        checkOutput("stall3 pc", pc_out, 32'h200);
        checkOutput("add rd", rd, 5'd3);
        checkOutput("add rs2", rs2, 5'd2);
        checkOutput("add fmt", fmt, 3'd0);
        checkOutput("add imm", imm, '0);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("release pc", pc_out, 32'h204);
        checkOutput("release in_ready", in_ready, 1'b1);
        checkOutput("sw fmt", fmt, 3'd2);
        checkOutput("sw imm", imm, 32'd12);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("release2 out_valid", out_valid, 1'b0);
        applyStimulus(1'b1, LUI, 32'h208, 1'b1, 1'b0);
        checkOutput("lui fmt", fmt, 3'd4);
        checkOutput("lui imm", imm, 32'h12345000);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Flush with two held and one offered
        applyStimulus(1'b1, ADD, 32'h300, 1'b0, 1'b0);
        applyStimulus(1'b1, SW, 32'h304, 1'b0, 1'b0);
        applyStimulus(1'b1, LUI, 32'h308, 1'b0, 1'b1);
        checkOutput("flush out_valid", out_valid, 1'b0);
        checkOutput("flush in_ready", in_ready, 1'b1);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checkOutput("flush lost", out_valid, 1'b0);

        // Illegal words flow through flagged
        applyStimulus(1'b1, 32'h0000007F, 32'h400, 1'b1, 1'b0);
        checkOutput("ill1 illegal", illegal, 1'b1);
        checkOutput("ill1 fmt", fmt, 3'd7);
        checkOutput("ill1 imm", imm, '0);
        applyStimulus(1'b1, 32'h00000010, 32'h404, 1'b1, 1'b0);
        checkOutput("ill2 illegal", illegal, 1'b1);
        checkOutput("ill2 fmt", fmt, 3'd7);
        checkOutput("ill2 imm", imm, '0);
        checkOutput("ill2 pc", pc_out, 32'h404);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Mixed traffic with irregular valid/ready and occasional flush
        begin
            int idx;
            logic v;
            idx = 0;
            for (int c = 0; c < 80; c++) begin
                v = ($urandom_range(0, 3) != 0);
                if (v && in_ready) idx = (idx + 1) % 12;
                applyStimulus(v, mix[idx], 32'h1000 + c * 4,
                              $urandom_range(0, 2) != 0,
                              $urandom_range(0, 15) == 0);
            end
        end
        repeat (3) applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        // Asynchronous reset with both entries full
        applyStimulus(1'b1, ADD, 32'h500, 1'b0, 1'b0);
        applyStimulus(1'b1, SW, 32'h504, 1'b0, 1'b0);
        checkOutput("full out_valid", out_valid, 1'b1);
        checkOutput("full in_ready", in_ready, 1'b0);
        reset = 1'b1;
        #1;
        checkOutput("areset out_valid", out_valid, 1'b0);
        checkOutput("areset in_ready", in_ready, 1'b1);
        checkOutput("areset opcode", opcode, '0);
        checkOutput("areset rd", rd, '0);
        checkOutput("areset imm", imm, '0);
        checkOutput("areset pc", pc_out, '0);
        checkOutput("areset fmt", fmt, '0);
        checkOutput("areset illegal", illegal, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(1'b1, ADDI, 32'h600, 1'b0, 1'b0);
        checkOutput("post-reset out_valid", out_valid, 1'b1);
        checkOutput("post-reset pc", pc_out, 32'h600);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipelined_decoder.md
PIPELINED_DECODER -- requirements
Module: pipelined_decoder

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 or 64.
REQ-002 Parameter PC_W, default 32, program-counter width carried alongside each instruction.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high; clears all state immediately on assertion.
REQ-005 in_valid  input  1  upstream offers instruction/pc this cycle.
REQ-006 in_ready  output  1  decoder accepts the offered word this cycle.
REQ-007 instruction  input  32  raw RV32 instruction word.
REQ-008 pc  input  PC_W  address of instruction.
REQ-009 flush  input  1  discard all held and incoming entries (branch redirect).
REQ-010 out_valid  output  1  decoded entry present on outputs.
REQ-011 out_ready  input  1  downstream consumes entry this cycle.
REQ-012 opcode 7, rd 5, funct3 3, rs1 5, rs2 5, funct7 7  outputs  decoded fields of head entry.
REQ-013 imm  output  XLEN  sign-extended immediate of head entry.
REQ-014 fmt  output  3  format code: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
REQ-015 illegal  output  1  head entry opcode unsupported or instruction[1:0] != 2'b11.
REQ-016 pc_out  output  PC_W  pc of head entry.

Function
REQ-017 Fields SHALL split as opcode[6:0], rd[11:7], funct3[14:12], rs1[19:15], rs2[24:20], funct7[31:25].
REQ-018 Format SHALL map opcode: 0110011->R; 0010011,0000011,1100111,1110011->I; 0100011->S; 1100011->B; 0110111,0010111->U; 1101111->J; anything else->illegal.
REQ-019 Immediates SHALL be: I {inst[31:20]}; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],1'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],1'b0}, each sign-extended from inst[31] to XLEN; U {inst[31:12],12'b0} sign-extended to XLEN; R and illegal imm = 0.
REQ-020 Decode SHALL be computed on input and registered; latency 1 cycle from accepted input to out_valid.
REQ-021 Storage SHALL be a two-entry buffer: head (drives outputs) and skid; order strictly FIFO.
REQ-022 in_ready SHALL equal "skid entry empty", registered (no combinational path from out_ready to in_ready).
REQ-023 Transfer in occurs when in_valid & in_ready; transfer out when out_valid & out_ready.
REQ-024 Empty + transfer in -> head loaded. Head full, no out, transfer in -> skid loaded, in_ready drops next cycle.
REQ-025 Head full, simultaneous in and out, skid empty -> new entry to head, skid stays empty.
REQ-026 Out with skid full -> skid moves to head, skid empty, in_ready rises next cycle.
REQ-027 Outputs SHALL stay stable while out_valid & !out_ready.
REQ-028 flush SHALL clear both entries next edge; any same-cycle input transfer is discarded; flush has priority over all transfers.
REQ-029 Illegal instructions SHALL flow through the pipeline like any other, flagged; decoder never stalls on them.

Reset
REQ-030 On reset: out_valid=0, in_ready=1, both entries invalid, opcode/rd/funct3/rs1/rs2/funct7/imm/pc_out=0, fmt=0, illegal=0.
REQ-031 Reset asserted mid-transfer SHALL drop all entries; first accept allowed on first edge after deassertion.

Verification
REQ-032 Accept 0x00500093 (addi x1,x0,5), out_ready=1 -> next cycle out_valid=1, opcode=0x13, rd=1, rs1=0, fmt=1, imm=5.
REQ-033 Accept 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC (XLEN=64: 0xFFFFFFFFFFFFFFFC).
REQ-034 out_ready=0, three back-to-back offers -> two accepted, in_ready=0 from cycle 2; release out_ready -> entries emerge in order, in_ready returns 1.
REQ-035 Two entries held, flush with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered word lost.
REQ-036 Accept 0x0000007F and 0x00000010 -> both emerge with illegal=1, fmt=7, imm=0.
REQ-037 Assert reset while head and skid full -> out_valid=0 immediately, all outputs zero, in_ready=1.
